// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: clocked instruction memory with a request/response fetch
// handshake (one fetch in flight), LATENCY-cycle read, a program-load write
// port and address-fault reporting on out-of-range or misaligned addresses.
// Optional build macro IMEM_FAULT_COUNT_EN adds a saturating 16-bit
// faulting-response counter (fault_count) with a synchronous clear
// (fault_count_clr).
module instr_mem_fetch #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int BYTE_ADDR = 1,
  parameter int LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`ifdef IMEM_FAULT_COUNT_EN
  ,
  output logic [15:0]       fault_count,
  input  logic              fault_count_clr
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range compare is done one bit wider than the address so that DEPTH
  // itself is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Latency counter preload: READ lasts LATENCY edges, the last one captures.
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  // Two address decoders share one structure: port 0 = latched fetch
  // address, port 1 = load address.
  localparam int NPORT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0]   resp_data_reg;
  logic                resp_fault_reg;
  logic                capture;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [NPORT-1:0][ADDR_W-1:0] dec_addr;
  logic [NPORT-1:0][ADDR_W-1:0] dec_word;
  logic [NPORT-1:0]             dec_align;
  logic [NPORT-1:0]             dec_ok;
  logic [NPORT-1:0][IDX_W-1:0]  dec_idx;

  assign dec_addr[0] = addr_reg;
  assign dec_addr[1] = load_addr;

  // Word index, alignment and range check per decoder. The index is formed
  // at full address width so large addresses never alias into the array.
  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_dec
      if (BYTE_ADDR != 0) begin : g_byte
        assign dec_word[gi]  = {2'b00, dec_addr[gi][ADDR_W-1:2]};
        assign dec_align[gi] = (dec_addr[gi][1:0] == 2'b00);
      end else begin : g_word
        assign dec_word[gi]  = dec_addr[gi];
        assign dec_align[gi] = 1'b1;
      end
      assign dec_ok[gi]  = dec_align[gi] && ({1'b0, dec_word[gi]} < DEPTH_EXT);
      assign dec_idx[gi] = dec_word[gi][IDX_W-1:0];
    end
  endgenerate

  // Requests are only taken in IDLE, and never while reset or flush is high.
  assign req_ready  = (state_reg == S_IDLE) && !rst && !flush;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_fault = resp_fault_reg;

  // FSM state, latency counter, latched address and response-valid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 2'd0;
      addr_reg       <= '0;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      resp_valid_reg <= resp_valid_next;
    end
  end

  // Next-state logic; flush overrides every state and suppresses capture.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    resp_valid_next = resp_valid_reg;
    capture         = 1'b0;
    if (flush) begin
      state_next      = S_IDLE;
      resp_valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_next  = req_addr;
            cnt_next   = CNT_INIT;
            state_next = S_READ;
          end
        end
        S_READ: begin
          if (cnt_reg != 2'd0) begin
            cnt_next = cnt_reg - 2'd1;
          end else begin
            capture         = 1'b1;
            resp_valid_next = 1'b1;
            state_next      = S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_next = 1'b0;
            state_next      = S_IDLE;
          end
        end
        default: begin
          state_next      = S_IDLE;
          resp_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Program-load write port; bad addresses are dropped silently. No reset
  // so the array maps onto block RAM and survives a core reset.
  always_ff @(posedge clk) begin
    if (load_en && dec_ok[1]) begin
      mem[dec_idx[1]] <= load_data;
    end
  end

  // Registered read into the response registers. A load to the same word on
  // the capture edge is not seen here (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data_reg  <= '0;
      resp_fault_reg <= 1'b0;
    end else if (capture) begin
      resp_fault_reg <= !dec_ok[0];
      resp_data_reg  <= dec_ok[0] ? mem[dec_idx[0]] : '0;
    end
  end

`ifdef IMEM_FAULT_COUNT_EN
  logic [15:0] fault_count_reg;

  assign fault_count = fault_count_reg;

  // Saturating count of faulting responses; clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || fault_count_clr) begin
      fault_count_reg <= 16'd0;
    end else if (capture && !dec_ok[0] && (fault_count_reg != 16'hFFFF)) begin
      fault_count_reg <= fault_count_reg + 16'd1;
    end
  end
`endif

endmodule
